// File: rtl/ukf_fifo_pkg.sv
// Shared definitions for the UKF matrix FIFO router: controller state encoding,
// header field placement and default geometry constants.
package ukf_fifo_pkg;

  // Controller states
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DIAG     = 3'd1,
    ST_LOWER    = 3'd2,
    ST_WAIT_FIN = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  // The matrix size sits in the low bits of the header word
  localparam int HDR_SIZE_LSB = 0;

  // Default geometry
  localparam int DEF_DATA_W   = 128;
  localparam int DEF_SIZE_W   = 6;
  localparam int DEF_LANES    = 4;
  localparam int DEF_MAX_SIZE = 32;

endpackage

// File: rtl/ukf_fifo_router_ctrl_if.sv
// Host write port plus diag/lower FIFO bank handshake, grouped for the router.
// slave  = the router controller, master = host / FIFO bank side.
interface ukf_fifo_router_ctrl_if #(
  parameter int DATA_W = 128,
  parameter int SIZE_W = 6,
  parameter int LANES  = 4
);
  logic              wr_enable;
  logic [DATA_W-1:0] din;
  logic              wr_ready;
  logic              full_diag;
  logic [LANES-1:0]  full_lower;
  logic [LANES-1:0]  empty_lower;
  logic              finish;
  logic              fifo_wre_diag;
  logic [LANES-1:0]  fifo_wre_lower;
  logic              fifo_rde_diag;
  logic              start_begin;
  logic              stop_pipeline;
  logic [SIZE_W-1:0] matrix_size_out;
  logic              size_err;

  modport slave (
    input  wr_enable, din, full_diag, full_lower, empty_lower, finish,
    output wr_ready, fifo_wre_diag, fifo_wre_lower, fifo_rde_diag,
           start_begin, stop_pipeline, matrix_size_out, size_err
  );

  modport master (
    output wr_enable, din, full_diag, full_lower, empty_lower, finish,
    input  wr_ready, fifo_wre_diag, fifo_wre_lower, fifo_rde_diag,
           start_begin, stop_pipeline, matrix_size_out, size_err
  );
endinterface

// File: rtl/ukf_lane_rr_sel.sv
// Round-robin lower-FIFO lane pointer. Advances one lane per accepted
// lower-triangle word, wraps LANES-1 -> 0, and exposes binary and one-hot forms.
module ukf_lane_rr_sel #(
  parameter int LANES  = 4,
  parameter int LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic              slow_clock,
  input  logic              rst,
  input  logic              advance,
  input  logic              clear,
  output logic [LANE_W-1:0] lane_idx,
  output logic [LANES-1:0]  lane_onehot
);
  logic [LANE_W-1:0] lane_reg;

  // Pointer update: reset/clear win over advance, explicit wrap for non-power-of-2 LANES
  always_ff @(posedge slow_clock) begin
    if (!rst || clear)
      lane_reg <= '0;
    else if (advance)
      lane_reg <= (lane_reg == LANE_W'(LANES - 1)) ? '0 : lane_reg + LANE_W'(1);
  end

  assign lane_idx = lane_reg;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_onehot
    assign lane_onehot[gi] = (lane_reg == LANE_W'(gi));
  end
endmodule

// File: rtl/ukf_fifo_router_ctrl.sv
// Input-side controller for the UKF matrix FIFOs: parses a size header, steers
// size diagonal words to the diag FIFO and size*(size-1)/2 lower-triangle words
// round-robin over LANES lower FIFOs, then holds until the core signals finish.
// Optional build macro UKF_FIFO_PROTO_CHECK_EN adds a sticky proto_err output.
module ukf_fifo_router_ctrl
  import ukf_fifo_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int SIZE_W   = DEF_SIZE_W,
  parameter int LANES    = DEF_LANES,
  parameter int MAX_SIZE = DEF_MAX_SIZE
) (
  input  logic slow_clock,
  input  logic rst,
  ukf_fifo_router_ctrl_if.slave bus
`ifdef UKF_FIFO_PROTO_CHECK_EN
  ,
  output logic proto_err
`endif
);
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CNT_W  = 2 * SIZE_W;

  state_t              state_reg;
  logic [SIZE_W-1:0]   size_reg;
  logic [CNT_W-1:0]    lower_total_reg;
  logic [SIZE_W-1:0]   diag_cnt_reg;
  logic [CNT_W-1:0]    low_cnt_reg;
  logic                fin_seen_reg;
  logic                rde_diag_reg;
  logic                start_reg;
  logic                size_err_reg;

  logic                wr_ready;
  logic                accept;
  logic [DATA_W-1:0]   din_word;
  logic [SIZE_W-1:0]   hdr_size;
  logic                hdr_bad;
  logic [CNT_W-1:0]    size_wide;
  logic [CNT_W-1:0]    lower_total_next;
  logic [LANE_W-1:0]   lane_idx;
  logic [LANES-1:0]    lane_onehot;

  assign din_word         = bus.din;
  assign hdr_size         = din_word[HDR_SIZE_LSB +: SIZE_W];
  assign hdr_bad          = (hdr_size == '0) || (hdr_size > SIZE_W'(MAX_SIZE));
  assign size_wide        = {{SIZE_W{1'b0}}, hdr_size};
  assign lower_total_next = (size_wide * (size_wide - CNT_W'(1))) >> 1;

  // Backpressure: a full target FIFO stalls the stream, no lane skipping
  always_comb begin
    wr_ready = 1'b0;
    case (state_reg)
      ST_IDLE:  wr_ready = 1'b1;
      ST_DIAG:  wr_ready = !bus.full_diag;
      ST_LOWER: wr_ready = !bus.full_lower[lane_idx];
      default:  wr_ready = 1'b0;
    endcase
  end

  assign accept = bus.wr_enable && wr_ready;

  ukf_lane_rr_sel #(.LANES(LANES), .LANE_W(LANE_W)) u_lane_sel (
    .slow_clock  (slow_clock),
    .rst         (rst),
    .advance     (accept && (state_reg == ST_LOWER)),
    .clear       (state_reg == ST_DONE),
    .lane_idx    (lane_idx),
    .lane_onehot (lane_onehot)
  );

  // Main sequencer: header parse, diag phase, lower phase, finish handshake
  always_ff @(posedge slow_clock) begin
    if (!rst) begin
      state_reg       <= ST_IDLE;
      size_reg        <= '0;
      lower_total_reg <= '0;
      diag_cnt_reg    <= '0;
      low_cnt_reg     <= '0;
      fin_seen_reg    <= 1'b0;
      rde_diag_reg    <= 1'b0;
      start_reg       <= 1'b0;
      size_err_reg    <= 1'b0;
    end else begin
      rde_diag_reg <= 1'b0;
      size_err_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            if (hdr_bad) begin
              size_err_reg <= 1'b1;
            end else begin
              size_reg        <= hdr_size;
              lower_total_reg <= lower_total_next;
              diag_cnt_reg    <= '0;
              low_cnt_reg     <= '0;
              state_reg       <= ST_DIAG;
            end
          end
        end
        ST_DIAG: begin
          if (bus.finish) fin_seen_reg <= 1'b1;
          if (accept) begin
            diag_cnt_reg <= diag_cnt_reg + SIZE_W'(1);
            // First diag word in flight: prefetch it and wake the core
            if (diag_cnt_reg == '0) begin
              rde_diag_reg <= 1'b1;
              start_reg    <= 1'b1;
            end
            if (diag_cnt_reg == size_reg - SIZE_W'(1))
              state_reg <= (lower_total_reg == '0) ? ST_WAIT_FIN : ST_LOWER;
          end
        end
        ST_LOWER: begin
          if (bus.finish) fin_seen_reg <= 1'b1;
          if (accept) begin
            low_cnt_reg <= low_cnt_reg + CNT_W'(1);
            if (low_cnt_reg == lower_total_reg - CNT_W'(1))
              state_reg <= ST_WAIT_FIN;
          end
        end
        ST_WAIT_FIN: begin
          if (bus.finish || fin_seen_reg) begin
            start_reg <= 1'b0;
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: begin
          diag_cnt_reg <= '0;
          low_cnt_reg  <= '0;
          fin_seen_reg <= 1'b0;
          state_reg    <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.wr_ready        = wr_ready;
  assign bus.fifo_wre_diag   = accept && (state_reg == ST_DIAG);
  assign bus.fifo_wre_lower  = (accept && (state_reg == ST_LOWER)) ? lane_onehot : '0;
  assign bus.fifo_rde_diag   = rde_diag_reg;
  assign bus.start_begin     = start_reg;
  assign bus.stop_pipeline   = |bus.empty_lower;
  assign bus.matrix_size_out = size_reg;
  assign bus.size_err        = size_err_reg;

`ifdef UKF_FIFO_PROTO_CHECK_EN
  logic proto_err_reg;

  // Sticky flag for writes into a stalled/closed port and stray finish in IDLE
  always_ff @(posedge slow_clock) begin
    if (!rst)
      proto_err_reg <= 1'b0;
    else if ((bus.wr_enable && !wr_ready &&
              (state_reg == ST_DIAG || state_reg == ST_LOWER || state_reg == ST_WAIT_FIN)) ||
             (bus.finish && state_reg == ST_IDLE))
      proto_err_reg <= 1'b1;
  end

  assign proto_err = proto_err_reg;
`endif
endmodule

// File: tb/tb_ukf_fifo_router_ctrl.sv
// Directed bench for ukf_fifo_router_ctrl (DATA_W=128, SIZE_W=6, LANES=4, MAX_SIZE=32).
module tb_ukf_fifo_router_ctrl;
  logic slow_clock = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 slow_clock = ~slow_clock;

  ukf_fifo_router_ctrl_if #(.DATA_W(128), .SIZE_W(6), .LANES(4)) bus ();

`ifdef UKF_FIFO_PROTO_CHECK_EN
  logic proto_err;
`endif

  ukf_fifo_router_ctrl #(.DATA_W(128), .SIZE_W(6), .LANES(4), .MAX_SIZE(32)) dut (
    .slow_clock (slow_clock),
    .rst        (rst),
    .bus        (bus.slave)
`ifdef UKF_FIFO_PROTO_CHECK_EN
    ,
    .proto_err  (proto_err)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge slow_clock);
    #1;
  endtask

  // One accepted-or-not word: check combinational handshake mid-cycle, then clock it
  task automatic push(input string tag, input logic [127:0] w, input logic exp_rdy,
                      input logic exp_wd, input logic [3:0] exp_wl);
    bus.wr_enable = 1'b1;
    bus.din       = w;
    #2;
    chk({tag, "_rdy"}, bus.wr_ready, exp_rdy);
    chk({tag, "_wre_diag"}, bus.fifo_wre_diag, exp_wd);
    chk({tag, "_wre_lower"}, bus.fifo_wre_lower, exp_wl);
    tick();
    bus.wr_enable = 1'b0;
    bus.din       = '0;
  endtask

  // Registered outputs plus wr_ready (state indicator) with no write offered
  task automatic chk_regs(input string tag, input logic exp_rde, input logic exp_start,
                          input logic [5:0] exp_size, input logic exp_err, input logic exp_rdy);
    #1;
    chk({tag, "_rde"}, bus.fifo_rde_diag, exp_rde);
    chk({tag, "_start"}, bus.start_begin, exp_start);
    chk({tag, "_size"}, bus.matrix_size_out, exp_size);
    chk({tag, "_size_err"}, bus.size_err, exp_err);
    chk({tag, "_rdy"}, bus.wr_ready, exp_rdy);
  endtask

  initial begin
    rst             = 1'b0;
    bus.wr_enable   = 1'b0;
    bus.din         = '0;
    bus.full_diag   = 1'b0;
    bus.full_lower  = '0;
    bus.empty_lower = '0;
    bus.finish      = 1'b0;
    tick();
    tick();
    chk_regs("reset", 1'b0, 1'b0, 6'd0, 1'b0, 1'b1);
    chk("reset_wre_lower", bus.fifo_wre_lower, 4'b0000);
    rst = 1'b1;

    // stop_pipeline is a plain OR of empty_lower
    bus.empty_lower = 4'b0010;
    #1;
    chk("stop_pipeline_set", bus.stop_pipeline, 1'b1);
    bus.empty_lower = 4'b0000;
    #1;
    chk("stop_pipeline_clr", bus.stop_pipeline, 1'b0);

    // 1: size 4 -> 4 diag, 6 lower on lanes 0,1,2,3,0,1
    push("t1_hdr", 128'd4, 1'b1, 1'b0, 4'b0000);
    chk_regs("t1_in_diag", 1'b0, 1'b0, 6'd4, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      push($sformatf("t1_diag%0d", i), 128'd100 + 128'(i), 1'b1, 1'b1, 4'b0000);
      if (i == 0) chk_regs("t1_first_diag", 1'b1, 1'b1, 6'd4, 1'b0, 1'b1);
      if (i == 1) chk_regs("t1_second_diag", 1'b0, 1'b1, 6'd4, 1'b0, 1'b1);
    end
    for (int k = 0; k < 6; k++)
      push($sformatf("t1_low%0d", k), 128'd200 + 128'(k), 1'b1, 1'b0, 4'(1 << (k % 4)));
    chk_regs("t1_wait_fin", 1'b0, 1'b1, 6'd4, 1'b0, 1'b0);
    bus.finish = 1'b1;
    tick();
    bus.finish = 1'b0;
    chk_regs("t1_done", 1'b0, 1'b0, 6'd4, 1'b0, 1'b0);
    tick();
    chk_regs("t1_idle", 1'b0, 1'b0, 6'd4, 1'b0, 1'b1);

    // 2: size 1 -> straight to WAIT_FIN, single rde pulse, port closed
    push("t2_hdr", 128'd1, 1'b1, 1'b0, 4'b0000);
    chk_regs("t2_in_diag", 1'b0, 1'b0, 6'd1, 1'b0, 1'b1);
    push("t2_diag", 128'd55, 1'b1, 1'b1, 4'b0000);
    chk_regs("t2_wait_fin", 1'b1, 1'b1, 6'd1, 1'b0, 1'b0);
    bus.wr_enable = 1'b1;
    #1;
    chk("t2_closed_wre_diag", bus.fifo_wre_diag, 1'b0);
    chk("t2_closed_wre_lower", bus.fifo_wre_lower, 4'b0000);
    tick();
    bus.wr_enable = 1'b0;
    chk_regs("t2_rde_once", 1'b0, 1'b1, 6'd1, 1'b0, 1'b0);
    bus.finish = 1'b1;
    tick();
    bus.finish = 1'b0;
    chk_regs("t2_done", 1'b0, 1'b0, 6'd1, 1'b0, 1'b0);
    tick();
    chk_regs("t2_idle", 1'b0, 1'b0, 6'd1, 1'b0, 1'b1);

    // 3: illegal headers 0 and 33
    push("t3_hdr0", 128'd0, 1'b1, 1'b0, 4'b0000);
    chk_regs("t3_err0", 1'b0, 1'b0, 6'd1, 1'b1, 1'b1);
    push("t3_hdr33", 128'd33, 1'b1, 1'b0, 4'b0000);
    chk_regs("t3_err33", 1'b0, 1'b0, 6'd1, 1'b1, 1'b1);
    tick();
    chk_regs("t3_clr", 1'b0, 1'b0, 6'd1, 1'b0, 1'b1);

    // 4: lane 2 full for 5 cycles stalls the stream, resumes on lane 2
    // 5: finish pulsed mid-LOWER is remembered
    push("t4_hdr", 128'd4, 1'b1, 1'b0, 4'b0000);
    for (int i = 0; i < 4; i++)
      push($sformatf("t4_diag%0d", i), 128'd300 + 128'(i), 1'b1, 1'b1, 4'b0000);
    push("t4_low0", 128'd400, 1'b1, 1'b0, 4'b0001);
    push("t4_low1", 128'd401, 1'b1, 1'b0, 4'b0010);
    bus.full_lower = 4'b0100;
    bus.wr_enable  = 1'b1;
    bus.din        = 128'd402;
    for (int c = 0; c < 5; c++) begin
      #2;
      chk($sformatf("t4_stall%0d_rdy", c), bus.wr_ready, 1'b0);
      chk($sformatf("t4_stall%0d_wre_lower", c), bus.fifo_wre_lower, 4'b0000);
      tick();
    end
    bus.wr_enable  = 1'b0;
    bus.full_lower = 4'b0000;
    push("t4_low2", 128'd402, 1'b1, 1'b0, 4'b0100);
    push("t4_low3", 128'd403, 1'b1, 1'b0, 4'b1000);
    bus.finish = 1'b1;
    tick();
    bus.finish = 1'b0;
    push("t5_low4", 128'd404, 1'b1, 1'b0, 4'b0001);
    push("t5_low5", 128'd405, 1'b1, 1'b0, 4'b0010);
    chk_regs("t5_wait_fin", 1'b0, 1'b1, 6'd4, 1'b0, 1'b0);
    tick();
    chk_regs("t5_done", 1'b0, 1'b0, 6'd4, 1'b0, 1'b0);
    tick();
    chk_regs("t5_idle", 1'b0, 1'b0, 6'd4, 1'b0, 1'b1);
`ifdef UKF_FIFO_PROTO_CHECK_EN
    chk("t5_proto_err", proto_err, 1'b1);
`endif

    // 6: reset mid-LOWER aborts the frame; next frame starts from lane 0
    push("t6_hdr", 128'd4, 1'b1, 1'b0, 4'b0000);
    for (int i = 0; i < 4; i++)
      push($sformatf("t6_diag%0d", i), 128'd500 + 128'(i), 1'b1, 1'b1, 4'b0000);
    push("t6_low0", 128'd600, 1'b1, 1'b0, 4'b0001);
    push("t6_low1", 128'd601, 1'b1, 1'b0, 4'b0010);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk_regs("t6_after_rst", 1'b0, 1'b0, 6'd0, 1'b0, 1'b1);
`ifdef UKF_FIFO_PROTO_CHECK_EN
    chk("t6_proto_err_clr", proto_err, 1'b0);
`endif
    push("t6_hdr3", 128'd3, 1'b1, 1'b0, 4'b0000);
    chk_regs("t6_in_diag", 1'b0, 1'b0, 6'd3, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      push($sformatf("t6_d3_%0d", i), 128'd700 + 128'(i), 1'b1, 1'b1, 4'b0000);
    for (int k = 0; k < 3; k++)
      push($sformatf("t6_l3_%0d", k), 128'd800 + 128'(k), 1'b1, 1'b0, 4'(1 << k));
    chk_regs("t6_wait_fin", 1'b0, 1'b1, 6'd3, 1'b0, 1'b0);
    bus.finish = 1'b1;
    tick();
    bus.finish = 1'b0;
    tick();
    chk_regs("t6_idle", 1'b0, 1'b0, 6'd3, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
